// File: rtl/fpu_issue_ctl_pkg.sv
// fpu_issue_ctl_pkg
// Shared definitions for the FP issue/writeback sequencer: FP opcodes,
// 16-bit float field helpers and the sequencer FSM state encoding.
// Float format: {sign[15], exp[14:7] bias 127, mant[6:0]}.
package fpu_issue_ctl_pkg;

    localparam logic [4:0] OPADDF = 5'h11;
    localparam logic [4:0] OPMULF = 5'h12;
    localparam logic [4:0] OPDIVF = 5'h13;
    localparam logic [4:0] OPITOF = 5'h14;
    localparam logic [4:0] OPFTOI = 5'h15;
    localparam logic [4:0] OPSUBF = 5'h16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    function automatic logic fpSign(input logic [15:0] f);
        return f[15];
    endfunction

    function automatic logic [7:0] fpExp(input logic [15:0] f);
        return f[14:7];
    endfunction

    function automatic logic [6:0] fpMant(input logic [15:0] f);
        return f[6:0];
    endfunction

    // Flip only the sign bit; exponent and mantissa are untouched.
    function automatic logic [15:0] fpNegate(input logic [15:0] f);
        return {~fpSign(f), fpExp(f), fpMant(f)};
    endfunction

    function automatic logic isLegalOp(input logic [4:0] op);
        return (op >= OPADDF) && (op <= OPSUBF);
    endfunction

endpackage

// File: rtl/fpu_issue_ctl.sv
// fpu_issue_ctl
// Issue/writeback sequencer in front of the fpu. Accepts one FP request at a
// time, drives the fpu, waits for done (with timeout), then emits a one-cycle
// writeback. SUBF is issued as ADDF with op2 negated. Exports a pending mask
// of destination registers with an outstanding writeback.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake from execute stage
//   req_op/req_rd/req_a/req_b   opcode, destination, operands
//   fpu_en/fpu_instr/fpu_op1/fpu_op2   issue to fpu
//   fpu_result/fpu_done         fpu response (done is a level, may be stale)
//   wb_valid/wb_rd/wb_data/wb_err      one-cycle writeback
//   pend_mask                   bit i set while r[i] writeback is outstanding
//   busy                        sequencer not idle
module fpu_issue_ctl
    import fpu_issue_ctl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [3:0]  req_rd,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        fpu_en,
    output logic [4:0]  fpu_instr,
    output logic [15:0] fpu_op1,
    output logic [15:0] fpu_op2,
    input  logic [15:0] fpu_result,
    input  logic        fpu_done,
    output logic        wb_valid,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        wb_err,
    output logic [15:0] pend_mask,
    output logic        busy
);

    state_t             r_state;
    state_t             w_stateNext;
    logic [4:0]         r_op;
    logic [3:0]         r_rd;
    logic [15:0]        r_a;
    logic [15:0]        r_b;
    logic [15:0]        r_result;
    logic               r_err;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_pend;
    logic               w_accept;
    logic               w_timeout;
    logic               w_issueActive;
    logic [15:0]        w_pendSet;
    logic [15:0]        w_pendClr;

    // The last WAIT cycle is the one where the counter has already counted
    // TIMEOUT-1 earlier cycles, giving exactly TIMEOUT cycles in WAIT.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // Next-state logic. ARM never looks at fpu_done, which masks a done level
    // left over from the previous op. In WAIT, done is tested before timeout
    // so a same-cycle done wins.
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_stateNext = isLegalOp(req_op) ? ST_ARM : ST_WB;
                end
            end
            ST_ARM:  w_stateNext = ST_WAIT;
            ST_WAIT: begin
                if (fpu_done || w_timeout) begin
                    w_stateNext = ST_WB;
                end
            end
            ST_WB:   w_stateNext = ST_IDLE;
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Request latch, wait counter and result capture. An illegal opcode is
    // marked as an error at accept time and never reaches the fpu.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_rd      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_op      <= req_op;
            r_rd      <= req_rd;
            r_a       <= req_a;
            r_b       <= req_b;
            r_result  <= '0;
            r_err     <= ~isLegalOp(req_op);
            r_illegal <= ~isLegalOp(req_op);
            r_cnt     <= '0;
        end else if (r_state == ST_WAIT) begin
            if (fpu_done) begin
                r_result <= fpu_result;
                r_err    <= 1'b0;
            end else if (w_timeout) begin
                r_result <= '0;
                r_err    <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Only one op is ever outstanding, so the set (IDLE) and clear (WB) of a
    // bit can never land in the same cycle.
    assign w_pendSet = w_accept ? (16'h0001 << req_rd) : 16'h0000;
    assign w_pendClr = (r_state == ST_WB) ? (16'h0001 << r_rd) : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend | w_pendSet) & ~w_pendClr;
        end
    end

    // fpu-facing values are held from ARM through WB and zero otherwise,
    // including the WB cycle of an illegal op that was never issued.
    assign w_issueActive = (r_state != ST_IDLE) && !r_illegal;

    always_comb begin
        fpu_instr = 5'h00;
        fpu_op1   = 16'h0000;
        fpu_op2   = 16'h0000;
        if (w_issueActive) begin
            fpu_op1 = r_a;
            if (r_op == OPSUBF) begin
                fpu_instr = OPADDF;
                fpu_op2   = fpNegate(r_b);
            end else begin
                fpu_instr = r_op;
                fpu_op2   = r_b;
            end
        end
    end

    // req_ready is gated by rst_n so every output reads zero while held in reset.
    assign req_ready = (r_state == ST_IDLE) && rst_n;
    assign fpu_en    = (r_state == ST_ARM) || (r_state == ST_WAIT);
    assign wb_valid  = (r_state == ST_WB);
    assign wb_rd     = wb_valid ? r_rd     : 4'h0;
    assign wb_data   = wb_valid ? r_result : 16'h0000;
    assign wb_err    = wb_valid ? r_err    : 1'b0;
    assign pend_mask = r_pend;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fpu_issue_ctl.sv
// tb_fpu_issue_ctl
// Directed bench for fpu_issue_ctl with a behavioural fpu whose done delay and
// returned value are programmed per operation.
module tb_fpu_issue_ctl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [3:0]  req_rd;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        fpu_en;
    logic [4:0]  fpu_instr;
    logic [15:0] fpu_op1;
    logic [15:0] fpu_op2;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        wb_err;
    logic [15:0] pend_mask;
    logic        busy;

    int          checkCount;
    int          errorCount;

    logic [7:0]  mdlDelay;
    logic [15:0] mdlResp;
    logic        mdlPreload;
    logic [7:0]  mdlCnt;
    logic        mdlDone;
    logic [15:0] mdlResult;

    fpu_issue_ctl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rd     (req_rd),
        .req_a      (req_a),
        .req_b      (req_b),
        .fpu_en     (fpu_en),
        .fpu_instr  (fpu_instr),
        .fpu_op1    (fpu_op1),
        .fpu_op2    (fpu_op2),
        .fpu_result (mdlResult),
        .fpu_done   (mdlDone),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_err     (wb_err),
        .pend_mask  (pend_mask),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural fpu: done is a level that stays up after completion. The
    // first enabled edge of a new op clears it; done rises on the edge where
    // the enabled-edge count reaches mdlDelay (0 = never).
    always @(posedge clk) begin
        if (fpu_en) begin
            mdlCnt <= mdlCnt + 8'd1;
            if (mdlCnt == 8'd0) begin
                mdlDone <= 1'b0;
            end
            if (mdlDelay != 8'd0 && (mdlCnt + 8'd1) == mdlDelay) begin
                mdlDone   <= 1'b1;
                mdlResult <= mdlResp;
            end
        end else begin
            mdlCnt <= 8'd0;
            if (mdlPreload) begin
                mdlDone   <= 1'b1;
                mdlResult <= 16'h1234;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents one request for a single accept edge, then returns at the
    // negedge after it (first cycle of ARM, or WB for an illegal op).
    task automatic applyStimulus(input logic [4:0] op, input logic [3:0] rd,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [7:0] delay, input logic [15:0] resp);
        @(negedge clk);
        mdlDelay  = delay;
        mdlResp   = resp;
        req_valid = 1'b1;
        req_op    = op;
        req_rd    = rd;
        req_a     = a;
        req_b     = b;
        checkOutput("readyBeforeAccept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic runOp(input string name, input logic [4:0] op,
                         input logic [3:0] rd, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] delay,
                         input logic [15:0] resp, input logic [4:0] expInstr,
                         input logic [15:0] expOp1, input logic [15:0] expOp2,
                         input logic [15:0] expData, input logic expErr,
                         input int expLat);
        int   lat;
        logic enSeen;
        applyStimulus(op, rd, a, b, delay, resp);
        lat    = 1;
        enSeen = fpu_en;
        checkOutput({name, ".pendSet"}, {16'd0, pend_mask}, 32'h1 << rd);
        checkOutput({name, ".instr"}, {27'd0, fpu_instr}, {27'd0, expInstr});
        checkOutput({name, ".op1"}, {16'd0, fpu_op1}, {16'd0, expOp1});
        checkOutput({name, ".op2"}, {16'd0, fpu_op2}, {16'd0, expOp2});
        while (!wb_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            enSeen = enSeen | fpu_en;
        end
        checkOutput({name, ".latency"}, lat, expLat);
        checkOutput({name, ".wbValid"}, {31'd0, wb_valid}, 32'd1);
        checkOutput({name, ".wbRd"}, {28'd0, wb_rd}, {28'd0, rd});
        checkOutput({name, ".wbData"}, {16'd0, wb_data}, {16'd0, expData});
        checkOutput({name, ".wbErr"}, {31'd0, wb_err}, {31'd0, expErr});
        checkOutput({name, ".enInWb"}, {31'd0, fpu_en}, 32'd0);
        checkOutput({name, ".enSeen"}, {31'd0, enSeen}, (expInstr != 5'h00) ? 32'd1 : 32'd0);
        @(negedge clk);
        checkOutput({name, ".wbDrop"}, {15'd0, wb_valid, wb_data}, 32'd0);
        checkOutput({name, ".pendClr"}, {16'd0, pend_mask}, 32'd0);
        checkOutput({name, ".idle"}, {30'd0, req_ready, busy}, 32'd2);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 5'h00;
        req_rd     = 4'h0;
        req_a      = 16'h0000;
        req_b      = 16'h0000;
        mdlDelay   = 8'd0;
        mdlResp    = 16'h0000;
        mdlPreload = 1'b0;
        mdlCnt     = 8'd0;
        mdlDone    = 1'b0;
        mdlResult  = 16'h0000;

        #2;
        checkOutput("resetOutputs",
                    {req_ready, fpu_en, wb_valid, wb_err, busy, fpu_instr, wb_rd},
                    32'd0);
        checkOutput("resetData", {fpu_op1, fpu_op2}, 32'd0);
        checkOutput("resetPend", {wb_data, pend_mask}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("readyAfterReset", {31'd0, req_ready}, 32'd1);

        // ADDF 1.0 + 1.0 = 2.0, done after 2 -> two WAIT cycles
        runOp("addf", 5'h11, 4'd7, 16'h3F80, 16'h3F80, 8'd2, 16'h4000,
              5'h11, 16'h3F80, 16'h3F80, 16'h4000, 1'b0, 4);

        // SUBF 2.0 - 1.0 issued as ADDF with op2 = -1.0
        runOp("subf", 5'h16, 4'd1, 16'h4000, 16'h3F80, 8'd1, 16'h3F80,
              5'h11, 16'h4000, 16'hBF80, 16'h3F80, 1'b0, 3);

        // Stale done with old result 1234 held at issue; real done after 3
        @(negedge clk);
        mdlPreload = 1'b1;
        @(negedge clk);
        mdlPreload = 1'b0;
        checkOutput("staleDoneHeld", {31'd0, mdlDone}, 32'd1);
        runOp("stale", 5'h12, 4'd4, 16'h4000, 16'h4000, 8'd3, 16'h4080,
              5'h12, 16'h4000, 16'h4000, 16'h4080, 1'b0, 5);

        // No done at all: abort after 16 WAIT cycles
        runOp("timeout", 5'h13, 4'd9, 16'h3F80, 16'h0000, 8'd0, 16'hFFFF,
              5'h13, 16'h3F80, 16'h0000, 16'h0000, 1'b1, 18);

        // Done in the last WAIT cycle, coinciding with timeout: done wins
        runOp("doneAtLimit", 5'h15, 4'd12, 16'h4120, 16'h0000, 8'd16, 16'h000A,
              5'h15, 16'h4120, 16'h0000, 16'h000A, 1'b0, 18);

        // Done one cycle before the limit
        runOp("doneBeforeLimit", 5'h11, 4'd0, 16'hC000, 16'h4000, 8'd15, 16'h0000,
              5'h11, 16'hC000, 16'h4000, 16'h0000, 1'b0, 17);

        // Illegal opcode (integer ADD): straight to WB with error, fpu untouched
        runOp("illegal", 5'h08, 4'd3, 16'h1111, 16'h2222, 8'd1, 16'h5555,
              5'h00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1);

        // Reset while waiting on r5
        applyStimulus(5'h11, 4'd5, 16'h3F80, 16'h3F80, 8'd0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        checkOutput("midOpPend", {16'd0, pend_mask}, 32'h0020);
        checkOutput("midOpEn", {30'd0, fpu_en, busy}, 32'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("rstEnDrop", {29'd0, fpu_en, busy, req_ready}, 32'd0);
        checkOutput("rstPendClr", {16'd0, pend_mask}, 32'd0);
        checkOutput("rstNoWb", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        checkOutput("rstHoldNoWb", {31'd0, wb_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rstReleaseReady", {31'd0, req_ready}, 32'd1);

        // ITOF 5 -> 5.0 after reset recovery
        runOp("itof", 5'h14, 4'd2, 16'h0005, 16'h0000, 8'd2, 16'h40A0,
              5'h14, 16'h0005, 16'h0000, 16'h40A0, 1'b0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
